instr_fetch: RTL and testbench

- Instruction-fetch front end for the Hack CPU. It is the consumer of the program counter value: it keeps its own fetch pointer and issues single-word reads to the instruction ROM over a req/ack interface.
- Returned words are buffered and presented to the CPU decode stage with a valid/ready handshake.
- A jump (the PC "load" event) arrives as a redirect. The redirect flushes the buffer and restarts fetch at the target address.

---
 rtl/hack_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/instr_fetch.sv | 132 +++++++++++++
 tb/tb_instr_fetch.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hack_pkg
// Description : Shared widths and state encoding for the Hack CPU fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
package hack_pkg;

    localparam int WORD_W  = 16;
    localparam int ADDR_W  = 16;
    // One buffer entry carries the fetch address above the instruction word.
    localparam int ENTRY_W = ADDR_W + WORD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small prefetch FIFO with synchronous push/pop/flush and an
//               occupancy count. Flush wins over push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import hack_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = ENTRY_W,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    // Pointers wrap explicitly so a depth of one still works.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == c_last_ptr) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Full-guarded push and empty-guarded pop keep the count in range.
    assign w_do_push = push && (r_count != c_full_cnt);
    assign w_do_pop  = pop  && (r_count != '0);

    // Storage, pointers and occupancy; flush empties without touching data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Hack CPU instruction-fetch front end. Issues single-word ROM
//               reads over req/ack, buffers returned words and hands them to
//               decode over valid/ready. A redirect flushes and refetches.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import hack_pkg::*;
#(
    parameter int                DEPTH      = 2,
    parameter logic [ADDR_W-1:0] RESET_ADDR = 16'h0000
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr
);

    localparam int               CNT_W      = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic [ADDR_W-1:0] w_fetch_addr_next;
    // Address of the abandoned request while draining; fetch_addr already
    // points at the redirect target by then.
    logic [ADDR_W-1:0] r_drain_addr;
    logic [ADDR_W-1:0] w_drain_addr_next;

    logic               w_complete;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_count_next;
    logic               w_space;
    logic [ENTRY_W-1:0] w_head;

    // A request is outstanding in every state except IDLE.
    assign w_complete   = (r_state != IDLE) && mem_ack;
    assign w_push       = (r_state == FETCH) && w_complete && !redirect;
    assign w_pop        = instr_valid && instr_ready;
    assign w_space      = (w_count != c_full_cnt);
    assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop && (w_count != '0));

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data ({r_fetch_addr, mem_rdata}),
        .pop       (w_pop),
        .flush     (redirect),
        .head_data (w_head),
        .count     (w_count)
    );

    assign instr_valid = (w_count != '0);
    assign instr_addr  = w_head[ENTRY_W-1:WORD_W];
    assign instr_data  = w_head[WORD_W-1:0];

    // State and fetch pointers advance on the clock, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_fetch_addr <= RESET_ADDR;
            r_drain_addr <= RESET_ADDR;
        end else begin
            r_state      <= w_state_next;
            r_fetch_addr <= w_fetch_addr_next;
            r_drain_addr <= w_drain_addr_next;
        end
    end

    // Next-state, pointer update and ROM request outputs.
    always_comb begin
        w_state_next      = r_state;
        w_fetch_addr_next = r_fetch_addr;
        w_drain_addr_next = r_drain_addr;
        mem_req           = 1'b0;
        mem_addr          = r_fetch_addr;

        case (r_state)
            IDLE: begin
                // A redirect flushes the buffer, so space is guaranteed.
                if (redirect || w_space) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                mem_req = 1'b1;
                if (redirect) begin
                    // An unfinished request must still be seen through.
                    w_state_next      = w_complete ? FETCH : DRAIN;
                    w_drain_addr_next = r_fetch_addr;
                end else if (w_complete) begin
                    w_fetch_addr_next = r_fetch_addr + ADDR_W'(1);
                    w_state_next      = (w_count_next != c_full_cnt) ? FETCH : IDLE;
                end
            end
            DRAIN: begin
                mem_req  = 1'b1;
                mem_addr = r_drain_addr;
                if (w_complete) begin
                    w_state_next = FETCH;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (redirect) begin
            w_fetch_addr_next = redirect_addr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch with a ROM model
//               whose ack latency is programmable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic [15:0] instr_addr;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_addr;

    int total = 0;
    int bad   = 0;
    int ack_lat = 0;
    int lat_cnt = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .DEPTH      (2),
        .RESET_ADDR (16'h0000)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_addr    (instr_addr),
        .instr_ready   (instr_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr)
    );

    // ROM contents: byte swap then a fixed xor pattern.
    function automatic logic [15:0] rom(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    assign mem_rdata = rom(mem_addr);
    assign mem_ack   = mem_req && (lat_cnt >= ack_lat);

    // Counts cycles a request has been waiting.
    always @(posedge clk) begin
        if (!mem_req || mem_ack) lat_cnt <= 0;
        else                     lat_cnt <= lat_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        redirect      = 1'b0;
        redirect_addr = 16'h0000;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        instr_ready = 1'b1;
        ack_lat     = 0;
        reset_n     = 1'b0;
        step();
        step();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        total++; if (instr_data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", instr_data); end
        total++; if (instr_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h exp=0000", instr_addr); end
        reset_n = 1'b1;
    endtask

    task automatic test_stream();
        instr_ready = 1'b1;
        ack_lat     = 0;
        do_reset();
        step();
        total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL stream_first_req req=%b addr=%h valid=%b exp=1/0000/0", mem_req, mem_addr, instr_valid);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            total++; if (instr_valid !== 1'b1 || instr_addr !== 16'(k) || instr_data !== rom(16'(k))) begin
                bad++; $display("FAIL stream_word valid=%b addr=%h data=%h exp=1/%h/%h", instr_valid, instr_addr, instr_data, 16'(k), rom(16'(k)));
            end
        end
    endtask

    task automatic test_backpressure();
        int got;
        logic [15:0] exp;
        instr_ready = 1'b0;
        ack_lat     = 0;
        do_reset();
        step(); step(); step();
        total++; if (mem_req !== 1'b0 || instr_valid !== 1'b1 || instr_addr !== 16'h0000) begin
            bad++; $display("FAIL bp_full req=%b valid=%b addr=%h exp=0/1/0000", mem_req, instr_valid, instr_addr);
        end
        step(); step();
        total++; if (mem_req !== 1'b0 || instr_addr !== 16'h0000) begin
            bad++; $display("FAIL bp_hold req=%b addr=%h exp=0/0000", mem_req, instr_addr);
        end
        instr_ready = 1'b1;
        got = 0;
        exp = 16'h0000;
        for (int cyc = 0; cyc < 20 && got < 6; cyc++) begin
            if (instr_valid === 1'b1) begin
                total++; if (instr_addr !== exp || instr_data !== rom(exp)) begin
                    bad++; $display("FAIL bp_order addr=%h data=%h exp=%h/%h", instr_addr, instr_data, exp, rom(exp));
                end
                exp = exp + 16'h1;
                got++;
            end
            step();
        end
        total++; if (got != 6) begin bad++; $display("FAIL bp_timeout consumed=%0d exp=6", got); end
    endtask

    task automatic test_redirect_drain();
        bit found;
        instr_ready = 1'b1;
        ack_lat     = 3;
        do_reset();
        redirect = 1'b1; redirect_addr = 16'h0005;
        step();
        redirect = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0005 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL drn_req5 req=%b addr=%h valid=%b exp=1/0005/0", mem_req, mem_addr, instr_valid);
        end
        redirect = 1'b1; redirect_addr = 16'h0040;
        step();
        redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0005 || instr_valid !== 1'b0) begin
                bad++; $display("FAIL drn_hold req=%b addr=%h valid=%b exp=1/0005/0", mem_req, mem_addr, instr_valid);
            end
            if (k < 2) step();
        end
        step();
        total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL drn_refetch req=%b addr=%h valid=%b exp=1/0040/0", mem_req, mem_addr, instr_valid);
        end
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            step();
            if (instr_valid === 1'b1) begin
                found = 1'b1;
                total++; if (instr_addr !== 16'h0040 || instr_data !== rom(16'h0040)) begin
                    bad++; $display("FAIL drn_first addr=%h data=%h exp=0040/%h", instr_addr, instr_data, rom(16'h0040));
                end
            end
        end
        total++; if (!found) begin bad++; $display("FAIL drn_timeout valid=%b exp=1", instr_valid); end
    endtask

    task automatic test_redirect_on_ack();
        instr_ready = 1'b1;
        ack_lat     = 0;
        do_reset();
        redirect = 1'b1; redirect_addr = 16'h0007;
        step();
        total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0007) begin
            bad++; $display("FAIL ack_req7 req=%b addr=%h exp=1/0007", mem_req, mem_addr);
        end
        redirect_addr = 16'h0100;
        step();
        redirect = 1'b0;
        total++; if (instr_valid !== 1'b0 || mem_addr !== 16'h0100) begin
            bad++; $display("FAIL ack_flush valid=%b addr=%h exp=0/0100", instr_valid, mem_addr);
        end
        step();
        total++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0100 || instr_data !== rom(16'h0100)) begin
            bad++; $display("FAIL ack_first valid=%b addr=%h data=%h exp=1/0100/%h", instr_valid, instr_addr, instr_data, rom(16'h0100));
        end
        step();
        total++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0101) begin
            bad++; $display("FAIL ack_second valid=%b addr=%h exp=1/0101", instr_valid, instr_addr);
        end
    endtask

    task automatic test_wrap();
        int got;
        logic [15:0] exp;
        instr_ready = 1'b1;
        ack_lat     = 0;
        do_reset();
        redirect = 1'b1; redirect_addr = 16'hFFFE;
        step();
        redirect = 1'b0;
        got = 0;
        exp = 16'hFFFE;
        for (int cyc = 0; cyc < 12 && got < 5; cyc++) begin
            if (instr_valid === 1'b1) begin
                total++; if (instr_addr !== exp || instr_data !== rom(exp)) begin
                    bad++; $display("FAIL wrap_seq addr=%h data=%h exp=%h/%h", instr_addr, instr_data, exp, rom(exp));
                end
                exp = exp + 16'h1;
                got++;
            end
            step();
        end
        total++; if (got != 5) begin bad++; $display("FAIL wrap_timeout consumed=%0d exp=5", got); end
    endtask

    task automatic test_async_reset();
        instr_ready = 1'b0;
        ack_lat     = 0;
        do_reset();
        step(); step();
        total++; if (mem_req !== 1'b1 || instr_valid !== 1'b1 || mem_addr !== 16'h0001) begin
            bad++; $display("FAIL arst_pre req=%b valid=%b addr=%h exp=1/1/0001", mem_req, instr_valid, mem_addr);
        end
        #3;
        reset_n = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 16'h0000) begin
            bad++; $display("FAIL arst_now req=%b valid=%b addr=%h exp=0/0/0000", mem_req, instr_valid, mem_addr);
        end
        #2;
        reset_n     = 1'b1;
        instr_ready = 1'b1;
        step();
        total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL arst_restart req=%b addr=%h valid=%b exp=1/0000/0", mem_req, mem_addr, instr_valid);
        end
        step();
        total++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0000 || instr_data !== rom(16'h0000)) begin
            bad++; $display("FAIL arst_first valid=%b addr=%h data=%h exp=1/0000/%h", instr_valid, instr_addr, instr_data, rom(16'h0000));
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 16'h0000;
        instr_ready   = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_redirect_on_ack();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
